mod_n_counter_arbiter: RTL and testbench
========================================

# mod_n_counter_arbiter

Round-robin arbiter and sequencer that shares one mod-N up/down counter among NREQ requesters. Each requester asks for a single step, up or down. The block grants requests one at a time, applies the step to its internal mod-N count register, and acknowledges the winner with the updated count. It sits between the client agents and the shared counter resource, and is the only writer of the count.

## Interface
- WIDTH, 4: count register width; requires N <= 2^WIDTH.
- N, 10: modulus; count range 0..N-1; requires N >= 2.
- NREQ, 4: number of requesters; requires NREQ >= 2.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req  in  NREQ  per-requester step request; level, held until acknowledged.
- i_dir  in  NREQ  per-requester direction: 1 = up, 0 = down. Valid while i_req is high.
- o_ack  out  NREQ  one-hot, one-cycle acknowledge to the winner.
- o_Q  out  WIDTH  current count.
- o_busy  out  1  high when the FSM is not in IDLE.
- o_last_id  out  $clog2(NREQ)  index of the most recent winner.

## Operation
- FSM states and transitions:
  - IDLE: if any i_req bit is high, go to STEP, latching the winner index and its i_dir bit. Otherwise stay in IDLE.
  - STEP: update the count; go to ACK.
  - ACK: pulse o_ack[winner]; load o_last_id with the winner; go to IDLE.
- Arbitration is round-robin:
  - Search starts at index (o_last_id + 1) mod NREQ and wraps; the first requester found with i_req high wins.
  - Only a completed ACK advances the pointer.
- Step arithmetic:
  - Up: Q == N-1 gives 0; otherwise Q+1.
  - Down: Q == 0 gives N-1; otherwise Q-1.
  - o_Q never holds a value >= N.
- i_req and i_dir are sampled only in IDLE. Changes during STEP or ACK are ignored.
- Requester protocol:
  - Hold i_req until o_ack is seen.
  - Deassert i_req at the clock edge that ends the ACK cycle, or keep it high to request another step.
- A requester that keeps i_req high re-enters arbitration in the next IDLE cycle. It does not have priority over the others.
- Simultaneous requests are served in round-robin order, one step each.
- Each grant is exactly one step.
- Reset, asynchronous, any state:
  - State goes to IDLE; o_Q = 0; o_ack = 0; o_busy = 0; o_last_id = NREQ-1, so requester 0 has first priority.
  - An operation in flight is dropped with no ack and no count change, unless STEP has already committed.

## Timing
- Edge t, IDLE with request: winner latched; state becomes STEP.
- Edge t+1: o_Q updated; state becomes ACK. o_Q shows the new value from t+1 onward.
- Cycle between t+1 and t+2: o_ack[winner] = 1; o_busy = 1.
- Edge t+2: state becomes IDLE; o_ack = 0; o_busy = 0.
- Latency from request to ack is 2 cycles. Sustained throughput is one step per 3 cycles.
- During the ack cycle, o_Q equals the post-step value; the requester may capture it there.
- o_ack is never multi-hot and never asserted outside ACK.
- o_busy is high in the STEP and ACK cycles only.

## Test plan
- Reset, then no requests for 10 cycles -> o_Q = 0, o_ack = 0, o_busy = 0, o_last_id = 3.
- Single requester: i_req[2] = 1, i_dir[2] = 1, held for 12 grants -> o_Q sequence 1..9, 0, 1, 2. Acks on o_ack[2] only, every 3 cycles.
- Down wrap: from o_Q = 0, requester 1 with dir 0 -> o_Q = 9. Next grant -> o_Q = 8.
- Contention: all 4 requesters high; directions up, up, down, up; start Q = 5.
  - Grants in order 0, 1, 2, 3, 0, ...
  - o_Q sequence 6, 7, 6, 7, ...
  - No requester is granted twice before every other active requester has been granted once.
- Protocol: i_dir toggled during STEP -> step uses the direction sampled in IDLE. Request dropped during ACK -> no further grant to that requester.
- Reset asserted asynchronously in the STEP cycle -> no ack is issued, state is IDLE, o_Q = 0, and the next grant goes to requester 0 if it is requesting.

Source files
------------

// File: rtl/mod_n_counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mod_n_counter_arbiter
// Brief    : Round-robin arbiter sharing one mod-N up/down counter among
//            NREQ single-step requesters (IDLE -> STEP -> ACK sequencer).
// Revision : 1.0
// ============================================================================
module mod_n_counter_arbiter #(
  parameter int WIDTH = 4,
  parameter int N     = 10,
  parameter int NREQ  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ-1:0]         i_dir,
  output logic [NREQ-1:0]         o_ack,
  output logic [WIDTH-1:0]        o_Q,
  output logic                    o_busy,
  output logic [$clog2(NREQ)-1:0] o_last_id
);

  localparam int c_id_w = $clog2(NREQ);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_step = 2'd1;
  localparam logic [1:0] c_ack  = 2'd2;

  localparam logic [WIDTH-1:0]  c_max     = WIDTH'(N - 1);
  localparam logic [WIDTH-1:0]  c_one     = WIDTH'(1);
  localparam logic [c_id_w-1:0] c_last_id = c_id_w'(NREQ - 1);
  localparam logic [c_id_w-1:0] c_id_one  = c_id_w'(1);

  logic [1:0]        state_q, state_d;
  logic [c_id_w-1:0] winner_q, winner_d;
  logic              dir_q, dir_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [c_id_w-1:0] last_id_q, last_id_d;

  logic              w_any_req;
  logic [c_id_w-1:0] w_grant_idx;
  logic [c_id_w-1:0] w_scan;
  logic              w_found;
  logic [WIDTH-1:0]  w_count_inc;
  logic [WIDTH-1:0]  w_count_dec;

  assign w_any_req = |i_req;

  // Scan starts one past the last winner and wraps, so the last winner is checked last.
  always_comb begin
    w_grant_idx = last_id_q;
    w_found     = 1'b0;
    w_scan      = last_id_q;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = (w_scan == c_last_id) ? '0 : w_scan + c_id_one;
      if (!w_found && i_req[w_scan]) begin
        w_found     = 1'b1;
        w_grant_idx = w_scan;
      end
    end
  end

  assign w_count_inc = (count_q == c_max) ? '0 : count_q + c_one;
  assign w_count_dec = (count_q == '0) ? c_max : count_q - c_one;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= c_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle:  state_d = w_any_req ? c_step : c_idle;
      c_step:  state_d = c_ack;
      c_ack:   state_d = c_idle;
      default: state_d = c_idle;
    endcase
  end

  // Outputs
  always_comb begin
    o_ack  = '0;
    o_busy = (state_q != c_idle);
    if (state_q == c_ack) begin
      o_ack[winner_q] = 1'b1;
    end
  end

  assign o_Q       = count_q;
  assign o_last_id = last_id_q;

  // Datapath: latch winner in IDLE, commit step in STEP, advance pointer in ACK
  always_comb begin
    winner_d  = winner_q;
    dir_d     = dir_q;
    count_d   = count_q;
    last_id_d = last_id_q;
    case (state_q)
      c_idle: begin
        if (w_any_req) begin
          winner_d = w_grant_idx;
          dir_d    = i_dir[w_grant_idx];
        end
      end
      c_step:  count_d   = dir_q ? w_count_inc : w_count_dec;
      c_ack:   last_id_d = winner_q;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      winner_q  <= '0;
      dir_q     <= 1'b0;
      count_q   <= '0;
      last_id_q <= c_last_id;
    end else begin
      winner_q  <= winner_d;
      dir_q     <= dir_d;
      count_q   <= count_d;
      last_id_q <= last_id_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mod_n_counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_n_counter_arbiter
// Brief    : Directed self-checking bench for mod_n_counter_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mod_n_counter_arbiter;

  logic       i_clk;
  logic       i_rst;
  logic [3:0] i_req;
  logic [3:0] i_dir;
  logic [3:0] o_ack;
  logic [3:0] o_Q;
  logic       o_busy;
  logic [1:0] o_last_id;

  int tests;
  int fails;

  mod_n_counter_arbiter #(.WIDTH(4), .N(10), .NREQ(4)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (i_req),
    .i_dir     (i_dir),
    .o_ack     (o_ack),
    .o_Q       (o_Q),
    .o_busy    (o_busy),
    .o_last_id (o_last_id)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Waits (bounded) for the next ack and checks its latency, winner and count.
  task automatic wait_ack(input int id, input int q, input int exp_n);
    int n;
    n = 0;
    while (n < 10) begin
      @(negedge i_clk);
      n++;
      if (o_ack != 4'b0) break;
    end
    check("ack_latency", n, exp_n);
    check("ack_id", o_ack, 32'(1) << id);
    check("ack_q", o_Q, q);
    check("ack_busy", o_busy, 1);
  endtask

  // Invariants sampled every cycle
  always @(negedge i_clk) begin
    check("ack_onehot0", $onehot0(o_ack), 1);
    check("q_range", (o_Q < 4'd10), 1);
  end

  initial begin
    int acks_seen;
    tests = 0;
    fails = 0;
    i_rst = 1'b1;
    i_req = 4'b0;
    i_dir = 4'b0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;

    // Idle after reset
    repeat (10) @(negedge i_clk);
    check("rst_q", o_Q, 0);
    check("rst_ack", o_ack, 0);
    check("rst_busy", o_busy, 0);
    check("rst_last_id", o_last_id, 3);

    // Single requester counting up through the wrap
    i_req = 4'b0100;
    i_dir = 4'b0100;
    for (int g = 0; g < 12; g++) begin
      wait_ack(2, (g + 1) % 10, (g == 0) ? 2 : 3);
    end
    i_req = 4'b0;
    @(negedge i_clk);
    check("single_idle_busy", o_busy, 0);
    check("single_last_id", o_last_id, 2);
    check("single_q", o_Q, 2);

    // Reset back to zero, then wrap downward
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("rst2_q", o_Q, 0);
    check("rst2_last_id", o_last_id, 3);
    i_req = 4'b0010;
    i_dir = 4'b0000;
    wait_ack(1, 9, 2);
    wait_ack(1, 8, 3);
    i_req = 4'b0;

    // Bring count to 5 with requester 3, leaving the pointer at 3
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    i_req = 4'b1000;
    i_dir = 4'b1000;
    for (int g = 0; g < 5; g++) begin
      wait_ack(3, g + 1, (g == 0) ? 2 : 3);
    end

    // Contention: dirs up, up, down, up
    i_req = 4'b1111;
    i_dir = 4'b1011;
    wait_ack(0, 6, 3);
    wait_ack(1, 7, 3);
    wait_ack(2, 6, 3);
    wait_ack(3, 7, 3);
    wait_ack(0, 8, 3);
    wait_ack(1, 9, 3);
    wait_ack(2, 8, 3);
    wait_ack(3, 9, 3);
    i_req = 4'b0;
    @(negedge i_clk);

    // Direction change during STEP must be ignored (9 up -> 0)
    i_req = 4'b0001;
    i_dir = 4'b0001;
    @(negedge i_clk);
    check("dir_step_busy", o_busy, 1);
    i_dir = 4'b0000;
    wait_ack(0, 0, 1);
    i_req = 4'b0;
    @(negedge i_clk);

    // Requester 1 drops at its ack, requester 2 still served, then silence
    i_req = 4'b0110;
    i_dir = 4'b0110;
    wait_ack(1, 1, 2);
    i_req = 4'b0100;
    wait_ack(2, 2, 3);
    i_req = 4'b0;
    acks_seen = 0;
    repeat (6) begin
      @(negedge i_clk);
      if (o_ack != 4'b0) acks_seen++;
    end
    check("drop_no_ack", acks_seen, 0);
    check("drop_q", o_Q, 2);
    check("drop_last_id", o_last_id, 2);

    // Asynchronous reset during STEP: pointer 2 would pick requester 3
    i_req = 4'b1001;
    i_dir = 4'b1001;
    @(negedge i_clk);
    check("arst_pre_busy", o_busy, 1);
    #2 i_rst = 1'b1;
    #1;
    check("arst_busy", o_busy, 0);
    check("arst_q", o_Q, 0);
    check("arst_ack", o_ack, 0);
    check("arst_last_id", o_last_id, 3);
    @(negedge i_clk);
    check("arst_hold_ack", o_ack, 0);
    i_rst = 1'b0;
    wait_ack(0, 1, 2);
    i_req = 4'b0;
    @(negedge i_clk);
    check("final_last_id", o_last_id, 0);
    check("final_busy", o_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
